mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single data-memory bus (16-bit address, 8-bit data, cs/we/oe) between two requesters: requester 0 is the CPU bus interface, requester 1 is a DMA/debug port.
- Runs one access at a time through a 3-state FSM, with round-robin fairness and a req/ack handshake.
- Addresses outside the mapped RAM window complete immediately with an error flag and never touch memory.
- Sits between the control unit's bus interface and the data RAM.

Parameters:
- ADDR_WIDTH, 16, address width.
- DATA_WIDTH, 8, data width.
- MEM_LATENCY, 2, cycles mem_cs is held per access (>=1).
- MEM_START_ADDR, 16'h0040, first valid RAM address (inclusive).
- MEM_STOP_ADDR, 16'h00BF, last valid RAM address (inclusive).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request, requester 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_WIDTH  access address.
- wdata0 / wdata1  in  DATA_WIDTH  write data.
- gnt0 / gnt1  out  1  high while the requester's access owns the bus.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err  out  1  valid with ack: address was out of range.
- rdata  out  DATA_WIDTH  read data, valid with ack; holds until the next completion.
- busy  out  1  FSM not in IDLE.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_cs / mem_we / mem_oe  out  1  memory strobes.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - All outputs 0, including mem_addr, mem_wdata and rdata.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Any access in flight is aborted: strobes drop immediately, no ack is issued.
- IDLE:
  - Arbitration with one request pending: that requester wins.
  - Arbitration with both pending: the requester that is not `last` wins.
  - On the edge, latch owner, addr, we and wdata.
  - If the latched address is in [MEM_START_ADDR, MEM_STOP_ADDR]: cnt = MEM_LATENCY-1, go to ACCESS.
  - Otherwise: set err=1, rdata=0, go to RESP.
  - No request pending: stay in IDLE.
- ACCESS:
  - gnt[owner]=1.
  - mem_cs=1, mem_we=we, mem_oe=!we.
  - mem_addr and mem_wdata are driven from the latched values, stable for all MEM_LATENCY cycles.
  - While cnt != 0: decrement cnt.
  - When cnt == 0: for a read, capture mem_rdata into rdata on that edge; for a write, rdata is unchanged. Set err=0, go to RESP.
- RESP:
  - ack[owner]=1 and gnt[owner]=1 for exactly one cycle.
  - mem_cs/we/oe = 0.
  - Set last=owner, go to IDLE.
- Handshake:
  - A requester holds req, we, addr and wdata stable from assertion until it samples ack.
  - It must deassert req on the edge where ack=1; req still high in the following IDLE cycle is a new request.
  - req dropped before ack is ignored: the latched access completes and acks.
- Latency:
  - Uncontended request: req sampled in IDLE at cycle t; mem_cs high t+1 .. t+MEM_LATENCY; ack at t+MEM_LATENCY+1.
  - Out-of-range request: ack at t+1.
  - Minimum spacing between back-to-back accesses: MEM_LATENCY+2 cycles.
- Fairness:
  - Under continuous contention, grants alternate 0,1,0,1…
  - Neither requester waits more than one foreign access.
- Invariants:
  - gnt0 & gnt1 is never 1.
  - ack only in RESP.
  - mem_cs only in ACCESS.
  - Boundary addresses MEM_START_ADDR and MEM_STOP_ADDR are valid; MEM_START_ADDR-1 and MEM_STOP_ADDR+1 are errors.

Test Plan:
- Reset then uncontended read: req0=1, we0=0, addr0=16'h0050, mem_rdata=8'hA5 -> mem_cs high 2 cycles with mem_oe=1 and mem_addr=0050; ack0 at the 3rd cycle after the request with rdata=A5, err=0.
- Write: req1=1, we1=1, addr1=16'h00BF, wdata1=8'h3C -> mem_we=1, mem_wdata=3C for 2 cycles; ack1 pulse; rdata unchanged.
- Contention from reset: req0 and req1 both high and continuously re-asserted -> grant order 0,1,0,1; gnt0 and gnt1 never both high; each ack spaced 4 cycles apart.
- Out of range: addr0=16'h003F, then addr0=16'h00C0 -> mem_cs stays 0; ack0 one cycle after the request with err=1 and rdata=00.
- Reset mid-access: drive reset=0 during the 2nd ACCESS cycle -> mem_cs, gnt and busy are 0 immediately; no ack. After release, req1 alone is granted first.
- MEM_LATENCY=1 instance plus a req held high after ack -> 1-cycle cs; the held req is treated as a second access and acked 3 cycles after the first ack.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle joining the two requesters, the arbiter and the data RAM.
// master: requester/memory side, slave: the arbiter.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  ack0, ack1;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_cs, mem_we, mem_oe;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, ack0, ack1, err, rdata, busy,
           mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, ack0, ack1, err, rdata, busy,
           mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the data-memory bus: one access at a
// time through IDLE -> ACCESS -> RESP, out-of-window addresses answered with err.
module mem_bus_arbiter #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MEM_LATENCY    = 2,
  parameter logic [ADDR_WIDTH-1:0] MEM_START_ADDR = 16'h0040,
  parameter logic [ADDR_WIDTH-1:0] MEM_STOP_ADDR  = 16'h00BF
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);
  localparam int              CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q;
  logic                  owner_q, last_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  gnt0_q, gnt1_q, ack0_q, ack1_q, err_q, busy_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_cs_q, mem_we_q, mem_oe_q;

  logic                  pick_d, any_req_d, we_d, in_range_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    pick_d = 1'b0;
    if (bus.req0 && bus.req1) pick_d = ~last_q;
    else if (bus.req1)        pick_d = 1'b1;
  end

  assign any_req_d  = bus.req0 | bus.req1;
  assign we_d       = pick_d ? bus.we1    : bus.we0;
  assign addr_d     = pick_d ? bus.addr1  : bus.addr0;
  assign wdata_d    = pick_d ? bus.wdata1 : bus.wdata0;
  assign in_range_d = (addr_d >= MEM_START_ADDR) && (addr_d <= MEM_STOP_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            owner_q <= pick_d;
            busy_q  <= 1'b1;
            gnt0_q  <= ~pick_d;
            gnt1_q  <= pick_d;
            if (in_range_d) begin
              state_q     <= ACCESS;
              cnt_q       <= CNT_INIT;
              mem_addr_q  <= addr_d;
              mem_wdata_q <= wdata_d;
              mem_cs_q    <= 1'b1;
              mem_we_q    <= we_d;
              mem_oe_q    <= ~we_d;
            end else begin
              // Out-of-window: answer straight away, memory is never strobed.
              state_q <= RESP;
              err_q   <= 1'b1;
              rdata_q <= '0;
              ack0_q  <= ~pick_d;
              ack1_q  <= pick_d;
            end
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!mem_we_q) rdata_q <= bus.mem_rdata;
            err_q    <= 1'b0;
            mem_cs_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_oe_q <= 1'b0;
            ack0_q   <= ~owner_q;
            ack1_q   <= owner_q;
            state_q  <= RESP;
          end
        end
        RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_oe    = mem_oe_q;
endmodule
